// File: rtl/mips_pkg.sv
// Shared constants for the fetch pipeline slice.
// Word-aligned PC helpers live here too.
package mips_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INC    = 32'd4;

  function automatic logic [XLEN-1:0] align4(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between fetch and imem.
// Read data is combinational for the presented address.
interface fetch_stage_if;
  import mips_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_addr,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    output imem_rdata
  );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// PC register with synchronous active-high reset
// and load enable.
module pc_reg
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RST_VAL = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [XLEN-1:0] d,
  output logic [XLEN-1:0] q
);

  logic [XLEN-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset)
      r_q <= RST_VAL;
    else if (en)
      r_q <= d;
  end

  assign q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: next-PC select, IF/ID latch with
// stall/flush/redirect, sticky misalign flag.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         flush,
  input  logic         branch_taken,
  input  logic [31:0]  branch_target,
  input  logic         jump,
  input  logic [31:0]  jump_target,
  fetch_stage_if.master imem,
  output logic [31:0]  pc,
  output logic [31:0]  ifid_instr,
  output logic [31:0]  ifid_pc4,
  output logic         ifid_valid,
  output logic         misalign
);

  logic        w_redirect;
  logic [31:0] w_target;
  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_next;
  logic        w_pc_en;

  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic        r_valid;
  logic        r_misalign;

  // Branch outranks jump; a redirect outranks stall.
  assign w_redirect = branch_taken | jump;
  assign w_target   = branch_taken ? branch_target
                                   : jump_target;
  assign w_pc_plus4 = w_pc + PC_INC;
  assign w_pc_next  = w_redirect ? align4(w_target)
                                 : w_pc_plus4;
  assign w_pc_en    = w_redirect | ~stall;

  pc_reg #(
    .RST_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .en    (w_pc_en),
    .d     (w_pc_next),
    .q     (w_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (w_redirect | flush) begin
      r_instr <= NOP_INSTR;
      r_pc4   <= '0;
      r_valid <= 1'b0;
    end else if (!stall) begin
      r_instr <= imem.imem_rdata;
      r_pc4   <= w_pc_plus4;
      r_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_misalign <= 1'b0;
    else if (w_redirect && (w_target[1:0] != 2'b00))
      r_misalign <= 1'b1;
  end

  assign imem.imem_addr = w_pc;
  assign pc             = w_pc;
  assign ifid_instr     = r_instr;
  assign ifid_pc4       = r_pc4;
  assign ifid_valid     = r_valid;
  assign misalign       = r_misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed vector bench for fetch_stage.
// imem model returns 32'h1111_0000 + address.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        misalign;

  int checks   = 0;
  int failures = 0;

  fetch_stage_if bus ();

  assign bus.imem_rdata = 32'h1111_0000 + bus.imem_addr;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .imem          (bus.master),
    .pc            (pc),
    .ifid_instr    (ifid_instr),
    .ifid_pc4      (ifid_pc4),
    .ifid_valid    (ifid_valid),
    .misalign      (misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        fls;
    logic        br;
    logic [31:0] bt;
    logic        jp;
    logic [31:0] jt;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic [31:0] e_pc4;
    logic        e_v;
    logic        e_m;
  } vec_t;

  function automatic vec_t mk(
    input logic        rst, stl, fls, br,
    input logic [31:0] bt,
    input logic        jp,
    input logic [31:0] jt,
    input logic [31:0] e_pc, e_ins, e_pc4,
    input logic        e_v, e_m
  );
    vec_t v;
    v.rst = rst; v.stl = stl; v.fls = fls;
    v.br = br; v.bt = bt; v.jp = jp; v.jt = jt;
    v.e_pc = e_pc; v.e_ins = e_ins; v.e_pc4 = e_pc4;
    v.e_v = e_v; v.e_m = e_m;
    return v;
  endfunction

  task automatic chk32(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    @(negedge clk);
    reset         = v.rst;
    stall         = v.stl;
    flush         = v.fls;
    branch_taken  = v.br;
    branch_target = v.bt;
    jump          = v.jp;
    jump_target   = v.jt;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    chk32({tag, ".pc"},    pc,         v.e_pc);
    chk32({tag, ".instr"}, ifid_instr, v.e_ins);
    chk32({tag, ".pc4"},   ifid_pc4,   v.e_pc4);
    chk32({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, v.e_v});
    chk32({tag, ".mis"},   {31'd0, misalign},   {31'd0, v.e_m});
  endtask

  localparam logic [31:0] B = 32'h1111_0000;

  vec_t tv[24];
  vec_t hv;

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    jump = 1'b0; jump_target = '0;

    //          rst stl fls br  bt       jp  jt            pc            instr         pc4           v  m
    tv[0]  = mk(1, 0, 0, 0, 0,     0, 0,            32'h0,        32'h0,        32'h0,        0, 0);
    tv[1]  = mk(0, 0, 0, 0, 0,     0, 0,            32'h4,        B + 32'h0,    32'h4,        1, 0);
    tv[2]  = mk(0, 0, 0, 0, 0,     0, 0,            32'h8,        B + 32'h4,    32'h8,        1, 0);
    tv[3]  = mk(0, 1, 0, 0, 0,     0, 0,            32'h8,        B + 32'h4,    32'h8,        1, 0);
    tv[4]  = mk(0, 1, 0, 0, 0,     0, 0,            32'h8,        B + 32'h4,    32'h8,        1, 0);
    tv[5]  = mk(0, 1, 0, 0, 0,     0, 0,            32'h8,        B + 32'h4,    32'h8,        1, 0);
    tv[6]  = mk(0, 0, 0, 0, 0,     0, 0,            32'hC,        B + 32'h8,    32'hC,        1, 0);
    tv[7]  = mk(0, 0, 0, 0, 0,     0, 0,            32'h10,       B + 32'hC,    32'h10,       1, 0);
    tv[8]  = mk(0, 0, 0, 1, 32'h40, 0, 0,           32'h40,       32'h0,        32'h0,        0, 0);
    tv[9]  = mk(0, 0, 0, 0, 0,     0, 0,            32'h44,       B + 32'h40,   32'h44,       1, 0);
    tv[10] = mk(0, 1, 0, 1, 32'h80, 1, 32'h100,     32'h80,       32'h0,        32'h0,        0, 0);
    tv[11] = mk(0, 0, 0, 0, 0,     0, 0,            32'h84,       B + 32'h80,   32'h84,       1, 0);
    tv[12] = mk(0, 0, 1, 0, 0,     0, 0,            32'h88,       32'h0,        32'h0,        0, 0);
    tv[13] = mk(0, 1, 1, 0, 0,     0, 0,            32'h88,       32'h0,        32'h0,        0, 0);
    tv[14] = mk(0, 0, 0, 0, 0,     0, 0,            32'h8C,       B + 32'h88,   32'h8C,       1, 0);
    tv[15] = mk(0, 0, 0, 0, 0,     1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0,      32'h0,        0, 0);
    tv[16] = mk(0, 0, 0, 0, 0,     0, 0,            32'h0,        32'h1110_FFFC, 32'h0,       1, 0);
    tv[17] = mk(0, 0, 0, 0, 0,     1, 32'h202,      32'h200,      32'h0,        32'h0,        0, 1);
    tv[18] = mk(0, 0, 0, 0, 0,     0, 0,            32'h204,      B + 32'h200,  32'h204,      1, 1);
    tv[19] = mk(0, 1, 0, 0, 0,     1, 32'h3,        32'h0,        32'h0,        32'h0,        0, 1);
    tv[20] = mk(0, 0, 0, 0, 0,     0, 0,            32'h4,        B + 32'h0,    32'h4,        1, 1);
    tv[21] = mk(1, 0, 0, 0, 0,     0, 0,            32'h0,        32'h0,        32'h0,        0, 0);
    tv[22] = mk(0, 0, 0, 1, 32'h40, 1, 32'h103,     32'h40,       32'h0,        32'h0,        0, 0);
    tv[23] = mk(0, 0, 0, 0, 0,     0, 0,            32'h44,       B + 32'h40,   32'h44,       1, 0);

    for (int i = 0; i < 24; i++) begin
      drive(tv[i]);
      check_all($sformatf("v%0d", i), tv[i]);
    end

    // Misaligned branch beats aligned jump; flag follows branch.
    hv = mk(0, 0, 0, 1, 32'h42, 1, 32'h100,
            32'h40, 32'h0, 32'h0, 0, 1);
    drive(hv);
    check_all("mis_br", hv);

    hv = mk(0, 0, 0, 0, 0, 0, 0,
            32'h44, B + 32'h40, 32'h44, 1, 1);
    drive(hv);
    check_all("mis_hold", hv);

    hv = mk(0, 1, 0, 0, 0, 0, 0,
            32'h44, B + 32'h40, 32'h44, 1, 1);
    drive(hv);
    check_all("pre_rst_stall", hv);

    // Reset during stall plus redirect plus flush.
    hv = mk(1, 1, 1, 1, 32'h80, 1, 32'h100,
            32'h0, 32'h0, 32'h0, 0, 0);
    drive(hv);
    check_all("rst_mid", hv);

    hv = mk(0, 0, 0, 0, 0, 0, 0,
            32'h4, B + 32'h0, 32'h4, 1, 0);
    drive(hv);
    check_all("post_rst", hv);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0000, meaning the instruction word inserted as a bubble.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hazard-unit request to hold the PC and the IF/ID contents.
REQ-006 SHALL have port flush  input  1  request to replace the IF/ID contents with a bubble.
REQ-007 SHALL have port branch_taken  input  1  branch resolved taken; redirects the PC.
REQ-008 SHALL have port branch_target  input  32  branch destination address.
REQ-009 SHALL have port jump  input  1  jump decoded; redirects the PC.
REQ-010 SHALL have port jump_target  input  32  jump destination address.
REQ-011 SHALL have port imem_addr  output  32  instruction-memory address, equal to pc.
REQ-012 SHALL have port imem_rdata  input  32  combinational instruction-memory read data for imem_addr.
REQ-013 SHALL have port pc  output  32  current fetch PC.
REQ-014 SHALL have port ifid_instr  output  32  latched instruction for decode.
REQ-015 SHALL have port ifid_pc4  output  32  latched PC+4 of ifid_instr.
REQ-016 SHALL have port ifid_valid  output  1  high when ifid_instr is a real instruction, low for a bubble.
REQ-017 SHALL have port misalign  output  1  sticky flag set when a redirect target has bits [1:0] not equal to 00.

Function
REQ-018 SHALL compute pc_plus4 = pc + 4, modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-019 SHALL select the next PC by fixed priority: branch_taken -> branch_target; else jump -> jump_target; else stall -> pc (hold); else pc_plus4.
REQ-020 SHALL force bits [1:0] of any redirect target to 00 before loading it into pc.
REQ-021 SHALL treat a redirect as branch_taken OR jump; a redirect overrides stall for both the PC and the IF/ID latch.
REQ-022 On a clock edge with a redirect or flush: SHALL load ifid_instr <= NOP_INSTR, ifid_pc4 <= 0, and ifid_valid <= 0.
REQ-023 On a clock edge with stall only (no redirect, no flush): SHALL hold ifid_instr, ifid_pc4 and ifid_valid unchanged.
REQ-024 Otherwise: SHALL load ifid_instr <= imem_rdata, ifid_pc4 <= pc_plus4, and ifid_valid <= 1.
REQ-025 When flush is asserted alone (no redirect, no stall): SHALL advance pc to pc_plus4 while inserting the bubble.
REQ-026 When flush and stall are both asserted: SHALL hold pc and insert the bubble.
REQ-027 SHALL set misalign on the edge when the selected redirect target has [1:0] != 00; misalign SHALL remain set until reset.
REQ-028 SHALL incur one cycle of latency from imem_rdata to ifid_instr; the taken-redirect penalty SHALL be exactly one bubble.

Reset
REQ-029 When reset is high at posedge clk: SHALL set pc <= RESET_PC, ifid_instr <= NOP_INSTR, ifid_pc4 <= 0, ifid_valid <= 0, and misalign <= 0.
REQ-030 Reset SHALL take priority over stall, flush and redirect, including when asserted mid-stall or mid-redirect.
REQ-031 SHALL have no asynchronous reset path; outputs before the first reset edge are undefined.

Structure
REQ-032 Shared package mips_pkg SHALL hold XLEN=32, NOP_INSTR, RESET_PC and the PC increment constant 4.
REQ-033 SHALL contain one sub-module, pc_reg: a 32-bit register with synchronous active-high reset and load enable, instantiated for pc.
REQ-034 The IF/ID latch and the next-PC selection logic SHALL be implemented inline.

Verification
REQ-035 Scenario 1: reset for 1 cycle, then free-run with imem_rdata = 32'h1111_0000 + pc -> pc sequence 0, 4, 8, 12; ifid_pc4 = 4, 8, 12; ifid_valid high from the second edge.
REQ-036 Scenario 2: stall held for 3 cycles at pc = 8 -> pc, ifid_instr and ifid_pc4 constant for 3 cycles, then pc resumes at 12.
REQ-037 Scenario 3: branch_taken with branch_target = 32'h40 at pc = 16 -> next pc = 32'h40, ifid_valid = 0 for one cycle, then instruction from 32'h40 latched with ifid_pc4 = 32'h44.
REQ-038 Scenario 4: branch_taken (target 32'h80), jump (target 32'h100) and stall in the same cycle -> pc = 32'h80 and a bubble is inserted.
REQ-039 Scenario 5: pc preloaded near 32'hFFFF_FFFC via jump -> following pc = 32'h0; jump_target = 32'h0000_0202 -> pc = 32'h200 and misalign = 1, which stays set until reset.
REQ-040 Scenario 6: reset asserted during an active stall and redirect -> all outputs return to their reset values on that edge.
